cvxif_relu_copro: RTL and testbench

- Parametrised CV-X-IF coprocessor for the custom-1 opcode (0101011) that supersedes the single fixed ReLU table entry.
- Decodes issue requests and queues accepted instructions in order.
- Waits for commit or kill of each instruction, computes scalar or packed-SIMD ReLU on rs1, and returns results with register writeback.
- Sits beside the CVA6 issue stage on the X-interface.

---
 rtl/cvxif_relu_pkg.sv | 65 ++++++
 rtl/cvxif_relu_lanes.sv | 30 +++
 rtl/cvxif_relu_copro.sv | 118 +++++++++++
 tb/tb_cvxif_relu_copro.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_relu_pkg.sv
// Decode table, execution modes and queue entry layout shared by the ReLU coprocessor and its lane datapath.
// Table rows are matched as (instr & mask) == instr; SIMD rows are ignored when packed modes are disabled.
package cvxif_relu_pkg;

  localparam logic [6:0] OpcodeCustom1 = 7'b0101011;
  localparam logic [2:0] Funct3Scalar  = 3'b000;
  localparam logic [2:0] Funct3Packed  = 3'b001;
  localparam logic [1:0] Lane8         = 2'b00;
  localparam logic [1:0] Lane16        = 2'b01;
  localparam logic [1:0] Lane32        = 2'b10;

  localparam logic [31:0] MaskScalar = 32'h0000_707F;
  localparam logic [31:0] MaskPacked = 32'h0600_707F;

  typedef enum logic [1:0] {
    MODE_SCALAR,
    MODE_P8,
    MODE_P16,
    MODE_P32
  } mode_e;

  typedef struct packed {
    logic  accept;
    logic  writeback;
    mode_e mode;
  } resp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] mask;
    logic        simd;
    resp_t       resp;
  } decode_entry_t;

  localparam decode_entry_t DecodeTable [4] = '{
    '{instr: {5'b0, 2'b00,  10'b0, Funct3Scalar, 5'b0, OpcodeCustom1}, mask: MaskScalar, simd: 1'b0,
      resp: '{accept: 1'b1, writeback: 1'b1, mode: MODE_SCALAR}},
    '{instr: {5'b0, Lane8,  10'b0, Funct3Packed, 5'b0, OpcodeCustom1}, mask: MaskPacked, simd: 1'b1,
      resp: '{accept: 1'b1, writeback: 1'b1, mode: MODE_P8}},
    '{instr: {5'b0, Lane16, 10'b0, Funct3Packed, 5'b0, OpcodeCustom1}, mask: MaskPacked, simd: 1'b1,
      resp: '{accept: 1'b1, writeback: 1'b1, mode: MODE_P16}},
    '{instr: {5'b0, Lane32, 10'b0, Funct3Packed, 5'b0, OpcodeCustom1}, mask: MaskPacked, simd: 1'b1,
      resp: '{accept: 1'b1, writeback: 1'b1, mode: MODE_P32}}
  };

  localparam int NbInstr = $size(DecodeTable);

  typedef struct packed {
    logic [4:0] rd;
    mode_e      mode;
    logic       committed;
    logic       killed;
  } entry_ctl_t;

  function automatic resp_t decode(input logic [31:0] instr, input logic en_simd);
    resp_t r;
    r = '0;
    for (int i = 0; i < NbInstr; i++) begin
      if (((instr & DecodeTable[i].mask) == DecodeTable[i].instr) && (en_simd || !DecodeTable[i].simd))
        r = DecodeTable[i].resp;
    end
    return r;
  endfunction

endpackage

// File: rtl/cvxif_relu_lanes.sv
// Combinational ReLU over XLEN bits: each lane is zeroed when its top bit is set.
// No carry or saturation crosses lane boundaries; P32 on a 32-bit datapath is a single lane.
module cvxif_relu_lanes
  import cvxif_relu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mode_e           mode,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out
);

  logic [XLEN-1:0] sign_bits;

  // Every bit looks up the sign bit of the lane it belongs to.
  always_comb begin
    sign_bits = '0;
    for (int i = 0; i < XLEN; i++) begin
      case (mode)
        MODE_P8:  sign_bits[i] = data_in[i | 7];
        MODE_P16: sign_bits[i] = data_in[i | 15];
        MODE_P32: sign_bits[i] = data_in[i | 31];
        default:  sign_bits[i] = data_in[XLEN-1];
      endcase
    end
  end

  assign data_out = data_in & ~sign_bits;

endmodule

// File: rtl/cvxif_relu_copro.sv
// CV-X-IF custom-1 ReLU coprocessor: in-order queue released by commit/kill, result one cycle after pop.
// Issue stalls when the queue is full or rs1 is not valid; the result register holds until result_ready_i.
module cvxif_relu_copro
  import cvxif_relu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int Depth   = 4,
  parameter int IdWidth = 3,
  parameter bit EnSimd  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic               issue_rs1_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               busy_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  resp_t              dec;
  logic [PtrW-1:0]    wr_ptr, rd_ptr;
  logic [PtrW:0]      count;
  logic [Depth-1:0]   occ;
  entry_ctl_t         ctl_q [Depth];
  logic [IdWidth-1:0] id_q  [Depth];
  logic [XLEN-1:0]    rs1_q [Depth];
  logic               push, pop, out_free, same_id;
  logic [XLEN-1:0]    relu_out;

  assign dec               = decode(issue_instr_i, EnSimd);
  assign issue_ready_o     = (count != DepthCnt) && issue_rs1_valid_i;
  assign issue_accept_o    = dec.accept;
  assign issue_writeback_o = dec.writeback;
  assign push              = issue_valid_i && issue_ready_o && dec.accept;
  assign out_free          = !result_valid_o || result_ready_i;
  assign pop               = occ[rd_ptr] && ctl_q[rd_ptr].committed && out_free;
  assign same_id           = commit_valid_i && (commit_id_i == issue_id_i);
  assign busy_o            = (count != '0) || result_valid_o;
  assign result_we_o       = result_valid_o;

  cvxif_relu_lanes #(.XLEN(XLEN)) u_lanes (
    .mode     (ctl_q[rd_ptr].mode),
    .data_in  (rs1_q[rd_ptr]),
    .data_out (relu_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
      for (int i = 0; i < Depth; i++) begin
        ctl_q[i] <= '0;
        id_q[i]  <= '0;
        rs1_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (commit_valid_i && occ[i] && (id_q[i] == commit_id_i)) begin
          ctl_q[i].committed <= 1'b1;
          ctl_q[i].killed    <= ctl_q[i].killed | commit_kill_i;
        end
      end
      // The write slot is never occupied, so a same-cycle commit is folded into the new entry here.
      if (push) begin
        ctl_q[wr_ptr] <= '{rd: issue_instr_i[11:7], mode: dec.mode,
                           committed: same_id, killed: same_id && commit_kill_i};
        id_q[wr_ptr]  <= issue_id_i;
        rs1_q[wr_ptr] <= issue_rs1_i;
        occ[wr_ptr]   <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
    end else if (pop && !ctl_q[rd_ptr].killed) begin
      result_valid_o <= 1'b1;
      result_id_o    <= id_q[rd_ptr];
      result_rd_o    <= ctl_q[rd_ptr].rd;
      result_data_o  <= relu_out;
    end else if (result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cvxif_relu_copro.sv
// Randomized and directed bench for cvxif_relu_copro against an in-order commit/kill reference queue.
module tb_cvxif_relu_copro;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [2:0]  issue_id_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic        issue_rs1_valid_i = 1'b0;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [2:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [31:0] result_data_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct {
    res_t res;
    bit   committed;
    bit   killed;
  } ment_t;

  ment_t mq[$];
  res_t  exp_q[$];
  res_t  got_q[$];

  cvxif_relu_copro #(.XLEN(32), .Depth(4), .IdWidth(3), .EnSimd(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs1_valid_i(issue_rs1_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .result_data_o(result_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Lane width in bits for an accepted instruction, 0 when it must be rejected.
  function automatic int ref_lane(input logic [31:0] instr);
    if (instr[6:0] != 7'h2B) return 0;
    if (instr[14:12] == 3'd0) return 32;
    if (instr[14:12] == 3'd1 && instr[26:25] != 2'd3) return 8 << instr[26:25];
    return 0;
  endfunction

  function automatic logic [31:0] relu_ref(input logic [31:0] v, input int w);
    longint unsigned lane, res, m;
    res = 0;
    m = (64'd1 << w) - 1;
    for (int l = 0; l < 32 / w; l++) begin
      lane = ({32'b0, v} >> (l * w)) & m;
      if (lane < (64'd1 << (w - 1))) res = res | (lane << (l * w));
    end
    return res[31:0];
  endfunction

  // Result handshakes complete at the posedge following a negedge where valid and ready are both high.
  always @(negedge clk_i) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      got_q.push_back('{id: result_id_o, rd: result_rd_o, data: result_data_o});
      checks++;
      if (result_we_o !== 1'b1) begin
        errors++;
        $display("FAIL result_we got %b expected 1", result_we_o);
      end
    end
  end

  task automatic do_issue(input logic [31:0] instr, input logic [2:0] id, input logic [31:0] rs1,
                          output logic acc, output logic wb);
    int  n = 0;
    int  w;
    logic hs;
    issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id;
    issue_rs1_i = rs1; issue_rs1_valid_i = 1'b1;
    #1;
    while (!issue_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout id=%0d ready=%b expected 1", id, issue_ready_o);
    end
    acc = issue_accept_o;
    wb  = issue_writeback_o;
    hs  = issue_ready_o;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
    w = ref_lane(instr);
    if (hs && w != 0)
      mq.push_back('{res: '{id: id, rd: instr[11:7], data: relu_ref(rs1, w)}, committed: 1'b0, killed: 1'b0});
  endtask

  task automatic do_commit(input logic [2:0] id, input bit kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    @(posedge clk_i); #1;
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    foreach (mq[i]) if (mq[i].res.id == id) begin
      mq[i].committed = 1'b1;
      if (kill) mq[i].killed = 1'b1;
    end
    while (mq.size() > 0 && mq[0].committed) begin
      if (!mq[0].killed) exp_q.push_back(mq[0].res);
      mq.delete(0);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 100) begin @(posedge clk_i); #1; n++; end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy got %b expected 0", name, busy_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%0d rd=%0d we=%b d=%h busy=%b expected all 0",
               result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, busy_o);
    end
    rst_i = 1'b0;
    issue_rs1_valid_i = 1'b0;
    #1;
    checks++;
    if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_norrs1 got %b expected 0", issue_ready_o); end
    issue_rs1_valid_i = 1'b1;
    #1;
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_rs1 got %b expected 1", issue_ready_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_scalar_simd;
    logic [31:0] instrs [4] = '{32'h0000_052B, 32'h0000_052B, 32'h0000_12AB, 32'h0200_12AB};
    logic [31:0] ops    [4] = '{32'hFFFF_FFF6, 32'h0000_0123, 32'h807F_FF01, 32'h8001_7FFF};
    logic [31:0] want   [4] = '{32'h0000_0000, 32'h0000_0123, 32'h007F_0001, 32'h0000_7FFF};
    logic acc, wb;
    result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_issue(instrs[k], 3'(k + 1), ops[k], acc, wb);
      checks++;
      if ({acc, wb} !== 2'b11) begin errors++; $display("FAIL direct_accept[%0d] got %b%b expected 11", k, acc, wb); end
      do_commit(3'(k + 1), 1'b0);
      wait_idle("direct");
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL direct_count got %0d expected 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_q[k] !== '{id: 3'(k + 1), rd: instrs[k][11:7], data: want[k]}) begin
          errors++;
          $display("FAIL direct_result[%0d] got id=%0d rd=%0d d=%h expected id=%0d rd=%0d d=%h",
                   k, got_q[k].id, got_q[k].rd, got_q[k].data, k + 1, instrs[k][11:7], want[k]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reject;
    logic [31:0] bad [3] = '{32'h0000_0533, 32'h0000_252B, 32'h0600_12AB};
    logic acc, wb;
    result_ready_i = 1'b1;
    foreach (bad[k]) begin
      do_issue(bad[k], 3'd5, $urandom(), acc, wb);
      checks++;
      if ({acc, wb} !== 2'b00) begin errors++; $display("FAIL reject_accept[%0d] got %b%b expected 00", k, acc, wb); end
      do_commit(3'd5, 1'b0);
    end
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (busy_o !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL reject_idle got busy=%b results=%0d expected 0 0", busy_o, got_q.size());
    end
  endtask

  task automatic test_kill_order;
    logic acc, wb;
    result_ready_i = 1'b1;
    for (int k = 2; k <= 4; k++) do_issue(32'h0000_102B | (k << 7), 3'(k), $urandom(), acc, wb);
    do_commit(3'd3, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL kill_hold got valid=%b busy=%b expected 0 1", result_valid_o, busy_o);
    end
    do_commit(3'd2, 1'b1);
    do_commit(3'd4, 1'b0);
    wait_idle("kill");
    checks++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL kill_count got %0d expected 2", got_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL kill_result[%0d] got %h expected %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure;
    logic acc, wb;
    int n;
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) do_issue(32'h0000_002B | (k << 7), 3'(k), $urandom(), acc, wb);
    issue_rs1_valid_i = 1'b1;
    #1;
    checks++;
    if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b expected 0", issue_ready_o); end
    for (int k = 0; k < 4; k++) do_commit(3'(k), 1'b0);
    n = 0;
    while (!result_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (!result_valid_o || {result_id_o, result_rd_o, result_data_o} !== exp_q[0]) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%b %h expected 1 %h", c, result_valid_o,
                 {result_id_o, result_rd_o, result_data_o}, exp_q[0]);
      end
      @(posedge clk_i); #1;
    end
    checks++;
    if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL refill_ready got %b expected 1", issue_ready_o); end
    do_issue(32'h0000_022B, 3'd4, $urandom(), acc, wb);
    do_commit(3'd4, 1'b0);
    result_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checks++;
      if (result_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b expected 1", c, result_valid_o); end
    end
    @(posedge clk_i); #1;
    wait_idle("stream");
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL stream_count got %0d expected 5", got_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL stream_result[%0d] got %h expected %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midop;
    logic acc, wb;
    int n = 0;
    result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) do_issue(32'h0000_002B | (k << 7), 3'(k + 5), 32'h0000_0042 + k, acc, wb);
    do_commit(3'd5, 1'b0);
    while (!result_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b id=%0d rd=%0d we=%b d=%h busy=%b expected all 0",
               result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o, busy_o);
    end
    mq.delete(); exp_q.delete(); got_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    result_ready_i = 1'b1;
    do_commit(3'd6, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (got_q.size() != 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL midreset_stale got results=%0d busy=%b expected 0 0", got_q.size(), busy_o);
    end
  endtask

  task automatic test_random;
    logic acc, wb;
    logic [31:0] instr;
    int n;
    for (int k = 0; k < 40; k++) begin
      instr = $urandom();
      case ($urandom_range(0, 6))
        0: instr[14:0] = {3'd0, instr[11:7], 7'h2B};
        1, 2, 3: begin instr[14:0] = {3'd1, instr[11:7], 7'h2B}; instr[26:25] = 2'($urandom_range(0, 2)); end
        4: instr[14:0] = {3'($urandom_range(2, 7)), instr[11:7], 7'h2B};
        5: begin instr[14:0] = {3'd1, instr[11:7], 7'h2B}; instr[26:25] = 2'd3; end
        default: instr[6:0] = 7'h33;
      endcase
      result_ready_i = 1'($urandom_range(0, 1));
      n = 0;
      while (!issue_ready_o && n < 20) begin result_ready_i = 1'b1; @(posedge clk_i); #1; n++; end
      do_issue(instr, 3'(k), $urandom(), acc, wb);
      checks++;
      if (acc !== (ref_lane(instr) != 0) || wb !== acc) begin
        errors++; $display("FAIL rand_accept[%0d] instr=%h got %b%b expected %0b", k, instr, acc, wb, ref_lane(instr) != 0);
      end
      if (acc) do_commit(3'(k), $urandom_range(0, 3) == 0);
    end
    result_ready_i = 1'b1;
    wait_idle("random");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (got_q[k]) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_result[%0d] got %h expected %h", k, got_q[k], exp_q[k]);
        end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_scalar_simd();
    test_reject();
    test_kill_order();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
